// File: rtl/adc_pkg.sv
// Shared types and constants for the dual-slope converter time base.
// The BCD increment helper keeps every decade inside 0..9.
package adc_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic {
    PH_INT = 1'b0,
    PH_REF = 1'b1
  } phase_e;

  function automatic bcd_t bcd_inc(input bcd_t d);
    if (d == BCD_MAX) begin
      return 4'd0;
    end else begin
      return d + 4'd1;
    end
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: synchronous clear, increment with roll-over at 9,
// and a combinational carry into the next decade.
module bcd_digit
  import adc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  bcd_t q_q;
  bcd_t q_d;

  // Next digit value: clear wins over increment.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      q_d = bcd_inc(q_q);
    end else begin
      q_d = q_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc && (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_conv_counter.sv
// Decimal time base for the dual-slope converter: counts integration and
// reference intervals and captures the BCD count on the integrator-zero edge.
module bcd_conv_counter
  import adc_pkg::*;
#(
  parameter int N_DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_0,
  input  logic                      clr,
  input  logic                      Vint_z,
  output logic                      en_3,
  output logic [4*N_DIGITS-1:0]     count,
  output logic [4*N_DIGITS-1:0]     result,
  output logic                      valid,
  output logic                      done,
  output logic                      ovf
);

  localparam int CW = BCD_W * N_DIGITS;

  logic [N_DIGITS-1:0] inc_s;
  logic [N_DIGITS-1:0] carry_s;
  logic [CW-1:0]       count_s;
  logic                wrap_s;
  logic                cap_s;

  phase_e          phase_q,   phase_d;
  logic            ovf_run_q, ovf_run_d;
  logic            vz_q;
  logic            en_3_q,    en_3_d;
  logic [CW-1:0]   result_q,  result_d;
  logic            valid_q,   valid_d;
  logic            done_q,    done_d;
  logic            ovf_q,     ovf_d;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign inc_s[k] = en_0;
    end else begin : g_upper
      assign inc_s[k] = carry_s[k-1];
    end

    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc_s[k]),
      .q     (count_s[k*BCD_W +: BCD_W]),
      .carry (carry_s[k])
    );
  end

  // A carry out of the top decade means the count wraps to all zeros this edge.
  assign wrap_s = carry_s[N_DIGITS-1];
  assign cap_s  = Vint_z && !vz_q && (phase_q == PH_REF);

  // Phase tracking and end-of-integration pulse; a clear suppresses a pending wrap.
  always_comb begin
    phase_d   = phase_q;
    ovf_run_d = ovf_run_q;
    en_3_d    = 1'b0;
    if (clr) begin
      phase_d   = PH_INT;
      ovf_run_d = 1'b0;
    end else if (wrap_s) begin
      if (phase_q == PH_INT) begin
        phase_d = PH_REF;
        en_3_d  = 1'b1;
      end else begin
        ovf_run_d = 1'b1;
      end
    end else begin
      phase_d   = phase_q;
      ovf_run_d = ovf_run_q;
    end
  end

  // Capture path: samples the pre-edge count, so a simultaneous clear is harmless.
  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (cap_s) begin
      result_d = count_s;
      ovf_d    = ovf_run_q;
      valid_d  = 1'b1;
      done_d   = 1'b1;
    end else begin
      result_d = result_q;
    end
  end

  // Control and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_INT;
      ovf_run_q <= 1'b0;
      vz_q      <= 1'b0;
      en_3_q    <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      ovf_run_q <= ovf_run_d;
      vz_q      <= Vint_z;
      en_3_q    <= en_3_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign count  = count_s;
  assign en_3   = en_3_q;
  assign result = result_q;
  assign valid  = valid_q;
  assign done   = done_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_bcd_conv_counter.sv
// Directed, table-driven bench for bcd_conv_counter with N_DIGITS=3.
module tb_bcd_conv_counter;

  logic        clk;
  logic        rst_n;
  logic        en_0;
  logic        clr;
  logic        Vint_z;
  logic        en_3;
  logic [11:0] count;
  logic [11:0] result;
  logic        valid;
  logic        done;
  logic        ovf;

  int total;
  int bad;

  typedef struct {
    logic        en;
    logic        cl;
    logic        vz;
    int          reps;
    logic [11:0] e_count;
    int          e_en3n;
    int          e_donen;
    logic        e_valid;
    logic [11:0] e_result;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  bcd_conv_counter #(.N_DIGITS(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_0   (en_0),
    .clr    (clr),
    .Vint_z (Vint_z),
    .en_3   (en_3),
    .count  (count),
    .result (result),
    .valid  (valid),
    .done   (done),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic cl, input logic vz, input int reps,
                     input logic [11:0] e_count, input int e_en3n, input int e_donen,
                     input logic e_valid, input logic [11:0] e_result, input logic e_ovf);
    vec_t v;
    v.en = en; v.cl = cl; v.vz = vz; v.reps = reps;
    v.e_count = e_count; v.e_en3n = e_en3n; v.e_donen = e_donen;
    v.e_valid = e_valid; v.e_result = e_result; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    en_0   = 1'b0;
    clr    = 1'b0;
    Vint_z = 1'b0;

    //   en    clr   vz    reps  count    en3 done valid result   ovf
    add(1'b1, 1'b0, 1'b0,    9, 12'h009, 0, 0, 1'b0, 12'h000, 1'b0);
    add(1'b1, 1'b0, 1'b0,    1, 12'h010, 0, 0, 1'b0, 12'h000, 1'b0);
    add(1'b1, 1'b0, 1'b0,   40, 12'h050, 0, 0, 1'b0, 12'h000, 1'b0);
    add(1'b0, 1'b0, 1'b1,    1, 12'h050, 0, 0, 1'b0, 12'h000, 1'b0);
    add(1'b0, 1'b0, 1'b0,    1, 12'h050, 0, 0, 1'b0, 12'h000, 1'b0);
    add(1'b1, 1'b0, 1'b0,   49, 12'h099, 0, 0, 1'b0, 12'h000, 1'b0);
    add(1'b1, 1'b0, 1'b0,    1, 12'h100, 0, 0, 1'b0, 12'h000, 1'b0);
    add(1'b1, 1'b0, 1'b0,  899, 12'h999, 0, 0, 1'b0, 12'h000, 1'b0);
    add(1'b1, 1'b0, 1'b0,    1, 12'h000, 1, 0, 1'b0, 12'h000, 1'b0);
    add(1'b1, 1'b0, 1'b0,  347, 12'h347, 0, 0, 1'b0, 12'h000, 1'b0);
    add(1'b0, 1'b0, 1'b1,    1, 12'h347, 0, 1, 1'b1, 12'h347, 1'b0);
    add(1'b0, 1'b0, 1'b1,    1, 12'h347, 0, 0, 1'b1, 12'h347, 1'b0);
    add(1'b1, 1'b1, 1'b0,    1, 12'h000, 0, 0, 1'b1, 12'h347, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1000, 12'h000, 1, 0, 1'b1, 12'h347, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1000, 12'h000, 0, 0, 1'b1, 12'h347, 1'b0);
    add(1'b1, 1'b0, 1'b0,   12, 12'h012, 0, 0, 1'b1, 12'h347, 1'b0);
    add(1'b0, 1'b0, 1'b1,    1, 12'h012, 0, 1, 1'b1, 12'h012, 1'b1);
    add(1'b0, 1'b0, 1'b0,    1, 12'h012, 0, 0, 1'b1, 12'h012, 1'b1);
    add(1'b0, 1'b1, 1'b0,    1, 12'h000, 0, 0, 1'b1, 12'h012, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1000, 12'h000, 1, 0, 1'b1, 12'h012, 1'b1);
    add(1'b1, 1'b0, 1'b0,  200, 12'h200, 0, 0, 1'b1, 12'h012, 1'b1);
    add(1'b0, 1'b1, 1'b1,    1, 12'h000, 0, 1, 1'b1, 12'h200, 1'b0);
    add(1'b0, 1'b0, 1'b1,    5, 12'h000, 0, 0, 1'b1, 12'h200, 1'b0);
    add(1'b0, 1'b1, 1'b0,    1, 12'h000, 0, 0, 1'b1, 12'h200, 1'b0);
    add(1'b1, 1'b0, 1'b0,  999, 12'h999, 0, 0, 1'b1, 12'h200, 1'b0);
    add(1'b1, 1'b1, 1'b0,    1, 12'h000, 0, 0, 1'b1, 12'h200, 1'b0);
    add(1'b1, 1'b0, 1'b0,  999, 12'h999, 0, 0, 1'b1, 12'h200, 1'b0);
    add(1'b1, 1'b0, 1'b0,    1, 12'h000, 1, 0, 1'b1, 12'h200, 1'b0);
    add(1'b1, 1'b0, 1'b0,    5, 12'h005, 0, 0, 1'b1, 12'h200, 1'b0);

    // Power-on reset held across a few edges.
    repeat (2) @(posedge clk);
    #1;
    chk("por_count",  32'(count),  32'h0);
    chk("por_result", 32'(result), 32'h0);
    chk("por_flags",  {27'd0, en_3, valid, done, ovf, 1'b0}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", 32'(count), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      int en3n;
      int donen;
      en3n  = 0;
      donen = 0;
      for (int r = 0; r < vecs[i].reps; r++) begin
        en_0   = vecs[i].en;
        clr    = vecs[i].cl;
        Vint_z = vecs[i].vz;
        @(posedge clk);
        #1;
        if (en_3) en3n++;
        if (done) donen++;
      end
      chk($sformatf("v%0d_count", i),  32'(count),  32'(vecs[i].e_count));
      chk($sformatf("v%0d_en3n", i),   32'(en3n),   32'(vecs[i].e_en3n));
      chk($sformatf("v%0d_donen", i),  32'(donen),  32'(vecs[i].e_donen));
      chk($sformatf("v%0d_valid", i),  32'(valid),  32'(vecs[i].e_valid));
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].e_result));
      chk($sformatf("v%0d_ovf", i),    32'(ovf),    32'(vecs[i].e_ovf));
    end

    // Asynchronous reset mid-count, checked before any further clock edge.
    en_0   = 1'b1;
    clr    = 1'b0;
    Vint_z = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_count",  32'(count),  32'h0);
    chk("async_result", 32'(result), 32'h0);
    chk("async_valid",  32'(valid),  32'h0);
    chk("async_flags",  {28'd0, en_3, done, ovf, 1'b0}, 32'h0);
    en_0 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_no_enable", 32'(count), 32'h0);
    en_0 = 1'b1;
    @(posedge clk);
    #1;
    chk("first_increment", 32'(count), 32'h001);
    en_0 = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_after_increment", 32'(count), 32'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
